// File: rtl/prefetcher_pkg.sv
// Shared types for the prefetcher read-address arbiter and its R router.
// Holds the source tag, the holding-register state and a default AR bundle.
package prefetcher_pkg;

  typedef enum logic {
    SRC_DEMAND   = 1'b0,
    SRC_PREFETCH = 1'b1
  } src_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  localparam int AR_ADDR_W = 16;
  localparam int AR_LEN_W  = 8;
  localparam int AR_ID_W   = 9;

  typedef struct packed {
    logic [AR_ADDR_W-1:0] addr;
    logic [AR_LEN_W-1:0]  len;
    logic [AR_ID_W-1:0]   id;
  } ar_req_t;

endpackage

// File: rtl/prefetch_r_router.sv
// Combinational R-channel demux: MSB of m_r_id selects demand/prefetch,
// the MSB is stripped on the way back; drop=1 sinks every beat.
module prefetch_r_router
  import prefetcher_pkg::*;
#(
  parameter int TID_WIDTH = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 drop,
  input  logic                 m_r_valid,
  output logic                 m_r_ready,
  input  logic                 m_r_last,
  input  logic [TID_WIDTH:0]   m_r_id,
  input  logic [DATA_W-1:0]    m_r_data,
  output logic                 d_r_valid,
  input  logic                 d_r_ready,
  output logic                 d_r_last,
  output logic [TID_WIDTH-1:0] d_r_id,
  output logic [DATA_W-1:0]    d_r_data,
  output logic                 p_r_valid,
  input  logic                 p_r_ready,
  output logic                 p_r_last,
  output logic [TID_WIDTH-1:0] p_r_id,
  output logic [DATA_W-1:0]    p_r_data
);

  src_e src;

  assign src = src_e'(m_r_id[TID_WIDTH]);

  assign d_r_valid = m_r_valid && !drop && (src == SRC_DEMAND);
  assign p_r_valid = m_r_valid && !drop && (src == SRC_PREFETCH);

  assign m_r_ready = drop ||
    ((src == SRC_PREFETCH) ? p_r_ready : d_r_ready);

  assign d_r_last = m_r_last;
  assign p_r_last = m_r_last;
  assign d_r_id   = m_r_id[TID_WIDTH-1:0];
  assign p_r_id   = m_r_id[TID_WIDTH-1:0];
  assign d_r_data = m_r_data;
  assign p_r_data = m_r_data;

endmodule

// File: rtl/prefetch_ar_arbiter.sv
// Shares the DRAM AR channel between demand and prefetch requests
// (demand first, prefetch throttled/limited/anti-starved) and routes R back.
module prefetch_ar_arbiter
  import prefetcher_pkg::*;
#(
  parameter int ADDR_BITS            = 16,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int LOG_QUEUE_SIZE       = 3,
  parameter int PRFETCH_FRQ_WIDTH    = 6,
  parameter int STARVE_LIMIT         = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           d_ar_valid,
  output logic                           d_ar_ready,
  input  logic [ADDR_BITS-1:0]           d_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]     d_ar_len,
  input  logic [TID_WIDTH-1:0]           d_ar_id,
  input  logic                           p_ar_valid,
  output logic                           p_ar_ready,
  input  logic [ADDR_BITS-1:0]           p_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]     p_ar_len,
  input  logic [TID_WIDTH-1:0]           p_ar_id,
  output logic                           m_ar_valid,
  input  logic                           m_ar_ready,
  output logic [ADDR_BITS-1:0]           m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]     m_ar_len,
  output logic [TID_WIDTH:0]             m_ar_id,
  input  logic                           m_r_valid,
  output logic                           m_r_ready,
  input  logic                           m_r_last,
  input  logic [TID_WIDTH:0]             m_r_id,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] m_r_data,
  output logic                           d_r_valid,
  input  logic                           d_r_ready,
  output logic                           d_r_last,
  output logic [TID_WIDTH-1:0]           d_r_id,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] d_r_data,
  output logic                           p_r_valid,
  input  logic                           p_r_ready,
  output logic                           p_r_last,
  output logic [TID_WIDTH-1:0]           p_r_id,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] p_r_data,
  input  logic [PRFETCH_FRQ_WIDTH-1:0]   crs_prBandwidthThrottle,
  input  logic [LOG_QUEUE_SIZE:0]        crs_prOutstandingLimit,
  output logic [LOG_QUEUE_SIZE:0]        prOutstanding
);

  localparam int DATA_W = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int OW     = LOG_QUEUE_SIZE + 1;
  localparam int SW     = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STV_MAX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_BITS-1:0]       addr;
    logic [BURST_LEN_WIDTH-1:0] len;
    logic [TID_WIDTH:0]         id;
  } req_t;

  arb_state_e                   state_q, state_d;
  req_t                         req_q, req_d;
  logic [PRFETCH_FRQ_WIDTH-1:0] thr_q, thr_d;
  logic [OW-1:0]                out_q, out_d;
  logic [SW-1:0]                stv_q, stv_d;

  logic pf_ok, gnt_p, gnt_d, can_load;
  logic ld_p, ld_d, r_ret_p;

  always_comb begin
    pf_ok = p_ar_valid && (thr_q == '0) &&
            (out_q < crs_prOutstandingLimit);
    gnt_p = pf_ok && (!d_ar_valid || (stv_q == STV_MAX));
    gnt_d = d_ar_valid && !gnt_p;
    can_load = (state_q == EMPTY) || m_ar_ready;
    ld_p = can_load && gnt_p && !rst;
    ld_d = can_load && gnt_d && !rst;
  end

  assign d_ar_ready    = ld_d;
  assign p_ar_ready    = ld_p;
  assign m_ar_valid    = (state_q == FULL);
  assign m_ar_addr     = req_q.addr;
  assign m_ar_len      = req_q.len;
  assign m_ar_id       = req_q.id;
  assign prOutstanding = out_q;

  // Only the last beat of a prefetch burst retires it.
  assign r_ret_p = m_r_valid && m_r_ready && m_r_last &&
                   m_r_id[TID_WIDTH];

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    if (ld_p) begin
      state_d = FULL;
      req_d   = '{addr: p_ar_addr, len: p_ar_len,
                  id: {1'(SRC_PREFETCH), p_ar_id}};
    end else if (ld_d) begin
      state_d = FULL;
      req_d   = '{addr: d_ar_addr, len: d_ar_len,
                  id: {1'(SRC_DEMAND), d_ar_id}};
    end else if ((state_q == FULL) && m_ar_ready) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    thr_d = thr_q;
    if (ld_p) thr_d = crs_prBandwidthThrottle;
    else if (thr_q != '0) thr_d = thr_q - 1'b1;
  end

  // Counted at grant time so the limit bounds bursts in the register too.
  always_comb begin
    out_d = out_q;
    unique case ({ld_p, r_ret_p && (out_q != '0)})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    stv_d = stv_q;
    if (ld_p || !pf_ok) stv_d = '0;
    else if (ld_d && (stv_q != STV_MAX)) stv_d = stv_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      req_q   <= '0;
      thr_q   <= '0;
      out_q   <= '0;
      stv_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      thr_q   <= thr_d;
      out_q   <= out_d;
      stv_q   <= stv_d;
    end
  end

  prefetch_r_router #(
    .TID_WIDTH(TID_WIDTH),
    .DATA_W   (DATA_W)
  ) u_r_router (
    .drop     (rst),
    .m_r_valid(m_r_valid),
    .m_r_ready(m_r_ready),
    .m_r_last (m_r_last),
    .m_r_id   (m_r_id),
    .m_r_data (m_r_data),
    .d_r_valid(d_r_valid),
    .d_r_ready(d_r_ready),
    .d_r_last (d_r_last),
    .d_r_id   (d_r_id),
    .d_r_data (d_r_data),
    .p_r_valid(p_r_valid),
    .p_r_ready(p_r_ready),
    .p_r_last (p_r_last),
    .p_r_id   (p_r_id),
    .p_r_data (p_r_data)
  );

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Self-checking bench for prefetch_ar_arbiter: R routing table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_prefetch_ar_arbiter;
  import prefetcher_pkg::*;

  localparam int AW = 16, LW = 8, TW = 8, LQ = 3, FW = 6, SL = 8, DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic d_ar_valid, d_ar_ready, p_ar_valid, p_ar_ready;
  logic [AW-1:0] d_ar_addr, p_ar_addr, m_ar_addr;
  logic [LW-1:0] d_ar_len, p_ar_len, m_ar_len;
  logic [TW-1:0] d_ar_id, p_ar_id;
  logic m_ar_valid, m_ar_ready;
  logic [TW:0] m_ar_id, m_r_id;
  logic m_r_valid, m_r_ready, m_r_last;
  logic [DW-1:0] m_r_data, d_r_data, p_r_data;
  logic d_r_valid, d_r_ready, d_r_last, p_r_valid, p_r_ready, p_r_last;
  logic [TW-1:0] d_r_id, p_r_id;
  logic [FW-1:0] thr_cfg;
  logic [LQ:0] lim_cfg, pr_out;

  always #5 clk = ~clk;

  prefetch_ar_arbiter #(
    .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(TW),
    .LOG_BLOCK_DATA_BYTES(0), .LOG_QUEUE_SIZE(LQ),
    .PRFETCH_FRQ_WIDTH(FW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready),
    .d_ar_addr(d_ar_addr), .d_ar_len(d_ar_len), .d_ar_id(d_ar_id),
    .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready),
    .p_ar_addr(p_ar_addr), .p_ar_len(p_ar_len), .p_ar_id(p_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .m_r_id(m_r_id), .m_r_data(m_r_data),
    .d_r_valid(d_r_valid), .d_r_ready(d_r_ready), .d_r_last(d_r_last),
    .d_r_id(d_r_id), .d_r_data(d_r_data),
    .p_r_valid(p_r_valid), .p_r_ready(p_r_ready), .p_r_last(p_r_last),
    .p_r_id(p_r_id), .p_r_data(p_r_data),
    .crs_prBandwidthThrottle(thr_cfg),
    .crs_prOutstandingLimit(lim_cfg),
    .prOutstanding(pr_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the holding register is a queue of at most one request.
  ar_req_t slot[$];
  int thr_m, out_m, stv_m;
  bit e_dr, e_pr, e_mrr, pok_m;
  bit saw_dr, saw_pr;

  task automatic half_check();
    bit gp, gd, cl, src;
    @(negedge clk);
    pok_m = p_ar_valid && (thr_m == 0) && (out_m < int'(lim_cfg));
    gp = pok_m && (!d_ar_valid || (stv_m == SL));
    gd = d_ar_valid && !gp;
    cl = (slot.size() == 0) || m_ar_ready;
    e_dr = !rst && cl && gd;
    e_pr = !rst && cl && gp;
    src = m_r_id[TW];
    e_mrr = rst || (src ? p_r_ready : d_r_ready);
    saw_dr = d_ar_ready;
    saw_pr = p_ar_ready;
    chk("d_ar_ready", d_ar_ready, e_dr);
    chk("p_ar_ready", p_ar_ready, e_pr);
    chk("m_ar_valid", m_ar_valid, slot.size() != 0);
    if (slot.size() != 0) begin
      chk("m_ar_addr", m_ar_addr, slot[0].addr);
      chk("m_ar_len", m_ar_len, slot[0].len);
      chk("m_ar_id", m_ar_id, slot[0].id);
    end
    chk("prOutstanding", pr_out, out_m);
    chk("m_r_ready", m_r_ready, e_mrr);
    chk("d_r_valid", d_r_valid, !rst && m_r_valid && !src);
    chk("p_r_valid", p_r_valid, !rst && m_r_valid && src);
  endtask

  task automatic half_commit();
    bit rf;
    ar_req_t r;
    @(posedge clk);
    if (rst) begin
      slot.delete();
      thr_m = 0;
      out_m = 0;
      stv_m = 0;
    end else begin
      rf = m_r_valid && e_mrr && m_r_last && m_r_id[TW];
      if (slot.size() != 0 && m_ar_ready) void'(slot.pop_front());
      if (e_dr) begin
        r.addr = d_ar_addr; r.len = d_ar_len; r.id = {1'b0, d_ar_id};
        slot.push_back(r);
      end
      if (e_pr) begin
        r.addr = p_ar_addr; r.len = p_ar_len; r.id = {1'b1, p_ar_id};
        slot.push_back(r);
      end
      if (e_pr) thr_m = int'(thr_cfg);
      else if (thr_m > 0) thr_m--;
      out_m = out_m + int'(e_pr) - int'(rf);
      if (e_pr || !pok_m) stv_m = 0;
      else if (e_dr && stv_m < SL) stv_m++;
    end
    #1;
  endtask

  task automatic step();
    half_check();
    half_commit();
  endtask

  task automatic idle();
    d_ar_valid = 0; p_ar_valid = 0; m_ar_ready = 1;
    m_r_valid = 0; m_r_last = 0; m_r_id = '0; m_r_data = '0;
    d_r_ready = 1; p_r_ready = 1;
  endtask

  task automatic ret_pf();
    m_r_valid = 1; m_r_last = 1; m_r_id = 9'h133; p_r_ready = 1;
    step();
    m_r_valid = 0; m_r_last = 0; m_r_id = '0;
  endtask

  typedef struct {
    logic mv; logic [TW:0] id; logic last; logic [DW-1:0] data;
    logic drr; logic prr; logic dv; logic pv; logic mrr;
  } rvec_t;
  rvec_t tv[6];

  int ng, lastc, cnt;
  bit exp_p;

  initial begin
    tv[0] = '{1'b1, 9'h005, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[1] = '{1'b1, 9'h1A3, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[2] = '{1'b1, 9'h1FF, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 9'h0FF, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 9'h012, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[5] = '{1'b1, 9'h080, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1; idle();
    d_ar_addr = '0; d_ar_len = '0; d_ar_id = '0;
    p_ar_addr = '0; p_ar_len = '0; p_ar_id = '0;
    thr_cfg = '0; lim_cfg = 4'd4;
    @(posedge clk); @(posedge clk); #1;
    slot.delete(); thr_m = 0; out_m = 0; stv_m = 0;

    // Reset state with requests and an R beat pending.
    d_ar_valid = 1; p_ar_valid = 1;
    m_r_valid = 1; m_r_id = 9'h001; d_r_ready = 0;
    half_check();
    chk("rst_m_r_ready", m_r_ready, 1);
    chk("rst_d_ar_ready", d_ar_ready, 0);
    chk("rst_p_ar_ready", p_ar_ready, 0);
    chk("rst_d_r_valid", d_r_valid, 0);
    half_commit();
    rst = 0; idle();
    half_check();
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_pr_out", pr_out, 0);
    half_commit();

    // R routing table.
    foreach (tv[i]) begin
      m_r_valid = tv[i].mv; m_r_id = tv[i].id; m_r_last = tv[i].last;
      m_r_data = tv[i].data; d_r_ready = tv[i].drr; p_r_ready = tv[i].prr;
      half_check();
      chk("tbl_d_r_valid", d_r_valid, tv[i].dv);
      chk("tbl_p_r_valid", p_r_valid, tv[i].pv);
      chk("tbl_m_r_ready", m_r_ready, tv[i].mrr);
      chk("tbl_d_r_id", d_r_id, tv[i].id[TW-1:0]);
      chk("tbl_p_r_id", p_r_id, tv[i].id[TW-1:0]);
      chk("tbl_d_r_data", d_r_data, tv[i].data);
      chk("tbl_p_r_last", p_r_last, tv[i].last);
      half_commit();
    end
    idle();

    // Demand only.
    d_ar_valid = 1; d_ar_addr = 16'h0eef; d_ar_len = 0; d_ar_id = 8'h05;
    half_check();
    chk("demand_grant", d_ar_ready, 1);
    half_commit();
    d_ar_valid = 0;
    half_check();
    chk("demand_m_ar_valid", m_ar_valid, 1);
    chk("demand_m_ar_id", m_ar_id, 9'h005);
    chk("demand_m_ar_addr", m_ar_addr, 16'h0eef);
    half_commit();
    m_r_valid = 1; m_r_last = 1; m_r_id = 9'h005;
    half_check();
    chk("demand_d_r_valid", d_r_valid, 1);
    chk("demand_d_r_id", d_r_id, 8'h05);
    half_commit();
    idle();
    half_check();
    chk("demand_pr_out", pr_out, 0);
    half_commit();

    // Throttle gap and outstanding limit.
    thr_cfg = 6'd10; lim_cfg = 4'd3;
    p_ar_valid = 1; p_ar_addr = 16'h1000; p_ar_len = 8'd3; p_ar_id = 8'h21;
    ng = 0; lastc = 0;
    for (int c = 0; c < 40; c++) begin
      half_check();
      if (saw_pr) begin
        if (ng > 0) chk("thr_gap", c - lastc, 11);
        lastc = c;
        ng++;
      end
      half_commit();
    end
    chk("thr_grants", ng, 3);
    chk("thr_out", pr_out, 3);
    ret_pf();
    half_check();
    chk("thr_regrant", p_ar_ready, 1);
    half_commit();
    p_ar_valid = 0;
    for (int c = 0; c < 11; c++) step();

    // Grant and prefetch R-last in the same cycle.
    thr_cfg = '0; lim_cfg = 4'd4; p_ar_valid = 1;
    m_r_valid = 1; m_r_last = 1; m_r_id = 9'h133;
    half_check();
    chk("sim_grant", p_ar_ready, 1);
    half_commit();
    idle();
    half_check();
    chk("sim_out", pr_out, 3);
    half_commit();

    // Limit of zero blocks prefetch completely.
    lim_cfg = '0; p_ar_valid = 1; cnt = 0;
    for (int c = 0; c < 10; c++) begin
      half_check();
      if (saw_pr) cnt++;
      half_commit();
    end
    chk("lim0_grants", cnt, 0);
    p_ar_valid = 0;
    for (int c = 0; c < 3; c++) ret_pf();

    // Starvation guard: 8 demand grants, then one prefetch.
    lim_cfg = 4'd15; thr_cfg = '0;
    d_ar_valid = 1; p_ar_valid = 1; d_ar_id = 8'h44; p_ar_id = 8'h77;
    for (int c = 0; c < 36; c++) begin
      half_check();
      exp_p = (c % 9) == 8;
      chk("starve_p", saw_pr, exp_p);
      chk("starve_d", saw_dr, !exp_p);
      if (c > 0) chk("starve_msb", m_ar_id[TW], ((c - 1) % 9) == 8);
      half_commit();
    end
    idle();
    for (int c = 0; c < 4; c++) ret_pf();
    chk("starve_drain", pr_out, 0);

    // Backpressure then back-to-back reload.
    m_ar_ready = 0; d_ar_valid = 1; d_ar_addr = 16'hA5A0;
    half_check();
    chk("bp_load", d_ar_ready, 1);
    half_commit();
    d_ar_addr = 16'h5A5F; p_ar_valid = 1;
    for (int c = 0; c < 5; c++) begin
      half_check();
      chk("bp_d_ready", d_ar_ready, 0);
      chk("bp_p_ready", p_ar_ready, 0);
      chk("bp_addr", m_ar_addr, 16'hA5A0);
      half_commit();
    end
    m_ar_ready = 1; p_ar_valid = 0;
    half_check();
    chk("bp_b2b", d_ar_ready, 1);
    half_commit();
    d_ar_valid = 0;
    half_check();
    chk("bp_b2b_valid", m_ar_valid, 1);
    chk("bp_b2b_addr", m_ar_addr, 16'h5A5F);
    half_commit();

    // Reset while FULL with two prefetches outstanding.
    idle(); lim_cfg = 4'd4; thr_cfg = '0; p_ar_valid = 1;
    step();
    thr_cfg = 6'd5;
    step();
    p_ar_valid = 0; d_ar_valid = 1;
    step();
    d_ar_valid = 0; m_ar_ready = 0;
    half_check();
    chk("pre_rst_out", pr_out, 2);
    chk("pre_rst_valid", m_ar_valid, 1);
    half_commit();
    rst = 1; m_r_valid = 1; m_r_id = 9'h002; d_r_ready = 0;
    half_check();
    chk("mid_rst_m_r_ready", m_r_ready, 1);
    half_commit();
    rst = 0; idle();
    half_check();
    chk("post_rst_valid", m_ar_valid, 0);
    chk("post_rst_out", pr_out, 0);
    chk("post_rst_thr", dut.thr_q, 0);
    half_commit();

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (c % 50 == 0) begin
        thr_cfg = 6'($urandom_range(0, 4));
        lim_cfg = 4'($urandom_range(0, 5));
      end
      d_ar_valid = 1'($urandom_range(0, 1));
      d_ar_addr = 16'($urandom); d_ar_len = 8'($urandom);
      d_ar_id = 8'($urandom);
      p_ar_valid = $urandom_range(0, 2) != 0;
      p_ar_addr = 16'($urandom); p_ar_len = 8'($urandom);
      p_ar_id = 8'($urandom);
      m_ar_ready = $urandom_range(0, 3) != 0;
      m_r_valid = 1'($urandom_range(0, 1));
      m_r_last = 1'($urandom_range(0, 1));
      m_r_id = {(out_m > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                8'($urandom)};
      m_r_data = 8'($urandom);
      d_r_ready = 1'($urandom_range(0, 1));
      p_r_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 0; idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
